// File: rtl/load_align_unit.sv
// Non-pipelined load unit: issues a word read, waits up to TIMEOUT cycles, then returns the extended byte/half/word.
// Latency is accept+2 cycles when the memory answers in the issue cycle; a held result blocks new requests until rsp_ready.
module load_align_unit #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [1:0]           req_lwhb,
  input  logic                 req_unsigned,
  input  logic [4:0]           req_rd,
  output logic                 mem_re,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_data,
  output logic [4:0]           rsp_rd,
  output logic [1:0]           rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TMO       = 8'(TIMEOUT);
  localparam logic [1:0] SZ_WORD   = 2'b01;
  localparam logic [1:0] SZ_HALF   = 2'b10;
  localparam logic [1:0] SZ_BYTE   = 2'b11;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  state_t      state, state_nxt;
  logic [1:0]  lwhb_q;
  logic [1:0]  addr_lo_q;
  logic        unsigned_q;
  logic [7:0]  cnt;
  logic        accept;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [XLEN-1:0] load_val;

  assign accept = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (req_lwhb)
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      SZ_HALF: misaligned = req_addr[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // Field selection uses the latched request, so mem_rdata only matters in the capture cycle.
  always_comb begin
    byte_sel = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = '0;
    case (lwhb_q)
      SZ_WORD: load_val = mem_rdata;
      SZ_HALF: load_val = {{(XLEN-16){~unsigned_q & half_sel[15]}}, half_sel};
      SZ_BYTE: load_val = {{(XLEN-8){~unsigned_q & byte_sel[7]}}, byte_sel};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = misaligned ? RESP : ISSUE;
      ISSUE: state_nxt = mem_rvalid ? RESP : WAIT;
      WAIT:  if (mem_rvalid || cnt == TMO) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_re    = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      rsp_data   <= '0;
      rsp_rd     <= '0;
      rsp_err    <= ERR_OK;
      cnt        <= '0;
      lwhb_q     <= '0;
      addr_lo_q  <= '0;
      unsigned_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rsp_rd     <= req_rd;
          lwhb_q     <= req_lwhb;
          addr_lo_q  <= req_addr[1:0];
          unsigned_q <= req_unsigned;
          cnt        <= '0;
          if (misaligned) begin
            rsp_err  <= ERR_ALIGN;
            rsp_data <= '0;
          end else begin
            mem_addr <= {req_addr[ADDR_SIZE-1:2], 2'b00};
          end
        end
        ISSUE: begin
          if (mem_rvalid) begin
            rsp_data <= load_val;
            rsp_err  <= ERR_OK;
          end else begin
            cnt <= 8'd1;
          end
        end
        WAIT: begin
          // A response arriving on the last allowed cycle still counts as success.
          if (mem_rvalid) begin
            rsp_data <= load_val;
            rsp_err  <= ERR_OK;
          end else if (cnt == TMO) begin
            rsp_data <= '0;
            rsp_err  <= ERR_TMO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: stimulus pushes expected responses and read addresses, a negedge monitor checks them.
module tb_load_align_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_lwhb;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_err;
  logic        busy;

  load_align_unit #(.XLEN(32), .ADDR_SIZE(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_lwhb(req_lwhb), .req_unsigned(req_unsigned), .req_rd(req_rd),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;
  logic [38:0] exp_q[$];   // {data, rd, err}
  logic [31:0] addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mem_re === 1'b1) begin
        if (addr_q.size() == 0) begin
          total++;
          fails++;
          $display("FAIL mem_re_unexpected: got mem_re=1 expected no read at %0t", $time);
        end else begin
          chk("mem_addr", mem_addr, addr_q.pop_front());
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          fails++;
          $display("FAIL rsp_unexpected: got rsp_data=0x%08h expected no response at %0t", rsp_data, $time);
        end else begin
          logic [38:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[38:7]);
          chk("rsp_rd", 32'(rsp_rd), 32'(e[6:2]));
          chk("rsp_err", 32'(rsp_err), 32'(e[1:0]));
        end
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_rd"}, 32'(rsp_rd), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] addr, input logic [1:0] lwhb, input logic uns, input logic [4:0] rd);
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    chk("req_ready_before_send", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = addr; req_lwhb = lwhb; req_unsigned = uns; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  // d = cycles after mem_re before rvalid (0 = in the issue cycle); d < 0 = memory never answers.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] lwhb, input logic uns,
                         input logic [4:0] rd, input logic [31:0] rdata, input int d,
                         input logic [31:0] exp_data, input logic [1:0] exp_err);
    exp_q.push_back({exp_data, rd, exp_err});
    if (exp_err != 2'b01) addr_q.push_back({addr[31:2], 2'b00});
    send(addr, lwhb, uns, rd);
    if (exp_err == 2'b01) begin
      chk("mis_mem_re", 32'(mem_re), 32'd0);
      chk("mis_lat", 32'(rsp_valid), 32'd1);
    end else if (d < 0) begin
      repeat (TMO) tick();
      chk("tmo_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("tmo_lat", 32'(rsp_valid), 32'd1);
    end else begin
      repeat (d) tick();
      chk("early_rsp", 32'(rsp_valid), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
      chk("lat", 32'(rsp_valid), 32'd1);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_lwhb = '0; req_unsigned = 1'b0;
    req_rd = '0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF; rsp_ready = 1'b1;
    repeat (2) tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();

    // Byte/half/word extraction patterns
    do_load(32'h80000003, 2'b11, 1'b0, 5'd5,  32'h80123456, 0, 32'hFFFFFF80, 2'b00);
    do_load(32'h80000102, 2'b10, 1'b1, 5'd6,  32'h9ABC1234, 3, 32'h00009ABC, 2'b00);
    do_load(32'h80000102, 2'b10, 1'b0, 5'd7,  32'h9ABC1234, 3, 32'hFFFF9ABC, 2'b00);
    do_load(32'h80000001, 2'b11, 1'b1, 5'd8,  32'h80123456, 1, 32'h00000034, 2'b00);
    do_load(32'h80000000, 2'b10, 1'b0, 5'd9,  32'h9ABC8234, 0, 32'hFFFF8234, 2'b00);
    do_load(32'h80000004, 2'b01, 1'b1, 5'd10, 32'hCAFEF00D, 2, 32'hCAFEF00D, 2'b00);
    do_load(32'h80000000, 2'b11, 1'b0, 5'd11, 32'h000000FF, 0, 32'hFFFFFFFF, 2'b00);
    do_load(32'h80000000, 2'b11, 1'b1, 5'd12, 32'h000000FF, 0, 32'h000000FF, 2'b00);

    // Misaligned and illegal size
    do_load(32'h80000002, 2'b01, 1'b0, 5'd13, 32'h0, 0, 32'h0, 2'b01);
    do_load(32'h80000001, 2'b10, 1'b0, 5'd14, 32'h0, 0, 32'h0, 2'b01);
    do_load(32'h80000000, 2'b00, 1'b0, 5'd15, 32'h0, 0, 32'h0, 2'b01);

    // Timeout, and rvalid on the final wait cycle
    do_load(32'h80000040, 2'b01, 1'b0, 5'd16, 32'h0, -1, 32'h0, 2'b10);
    do_load(32'h80000040, 2'b01, 1'b0, 5'd17, 32'h13579BDF, TMO, 32'h13579BDF, 2'b00);

    // Backpressure with stray rvalid and a blocked request
    rsp_ready = 1'b0;
    exp_q.push_back({32'hFFFFFF88, 5'd18, 2'b00});
    addr_q.push_back(32'h80000200);
    send(32'h80000201, 2'b11, 1'b0, 5'd18);
    mem_rvalid = 1'b1; mem_rdata = 32'h11228844;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'hFFFFFF88);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_rd", 32'(rsp_rd), 32'd18);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      if (i == 2) begin
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        req_valid = 1'b1; req_addr = 32'h80000300; req_lwhb = 2'b01;
      end
      tick();
      mem_rvalid = 1'b0; req_valid = 1'b0; mem_rdata = 32'hDEADBEEF;
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset while waiting drops the load
    addr_q.push_back(32'h80000300);
    send(32'h80000300, 2'b01, 1'b0, 5'd19);
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("wait_reset");
    do_load(32'h80000010, 2'b01, 1'b0, 5'd20, 32'h12345678, 1, 32'h12345678, 2'b00);

    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
